// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit for the multicycle CPU: owns PC and IR, fetches over a
// req/ack/valid handshake and applies the controller's PC update on instr_done.
module instr_fetch_unit #(
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clock,
   input  logic                  reset,
   output logic                  mem_rd_req,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic                  mem_rd_ack,
   input  logic                  mem_rd_valid,
   input  logic [31:0]           mem_rd_data,
   output logic [5:0]            OPcode,
   output logic [31:0]           instr,
   output logic                  instr_valid,
   input  logic                  instr_done,
   input  logic                  PCWrite,
   input  logic                  PCWriteCond,
   input  logic                  BEQ,
   input  logic [1:0]            PCSrc,
   input  logic                  zero,
   output logic [ADDR_WIDTH-1:0] pc,
   output logic [31:0]           retired
);

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned IMM_W   = 16;
   localparam int unsigned JIDX_W  = 26;
   localparam int unsigned OP_LSB  = 26;

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_WAIT  = 2'd1,
      S_ISSUE = 2'd2
   } state_t;

   state_t                state_q;
   logic [ADDR_WIDTH-1:0] pc_q;
   logic [INSTR_W-1:0]    ir_q;
   logic [INSTR_W-1:0]    retired_q;
   logic                  req_q;
   logic                  valid_q;

   logic [ADDR_WIDTH-1:0] pc_plus1;
   logic [ADDR_WIDTH-1:0] imm_sext;
   logic [ADDR_WIDTH-1:0] branch_target;
   logic [ADDR_WIDTH-1:0] jump_target;
   logic                  branch_taken;
   logic [ADDR_WIDTH-1:0] pc_d;

   // Candidate next-PC values; only consumed on the instr_done edge in ISSUE.
   always_comb begin
      pc_plus1      = pc_q + ADDR_WIDTH'(1);
      imm_sext      = {{(ADDR_WIDTH-IMM_W){ir_q[IMM_W-1]}}, ir_q[IMM_W-1:0]};
      branch_target = pc_plus1 + imm_sext;
      jump_target   = {pc_plus1[ADDR_WIDTH-1:JIDX_W], ir_q[JIDX_W-1:0]};
      branch_taken  = PCWriteCond && (BEQ ? zero : !zero);
      pc_d          = pc_plus1;
      if (PCWrite) begin
         case (PCSrc)
            2'd1:    pc_d = branch_target;
            2'd2:    pc_d = jump_target;
            default: pc_d = pc_plus1;
         endcase
      end else if (branch_taken) begin
         pc_d = branch_target;
      end
   end

   // FSM plus registered handshake/status outputs that track the state.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= S_FETCH;
         pc_q      <= RESET_PC;
         ir_q      <= '0;
         retired_q <= '0;
         req_q     <= 1'b1;
         valid_q   <= 1'b0;
      end else begin
         case (state_q)
            S_FETCH: begin
               if (mem_rd_ack) begin
                  state_q <= S_WAIT;
                  req_q   <= 1'b0;
               end
            end
            S_WAIT: begin
               if (mem_rd_valid) begin
                  ir_q    <= mem_rd_data;
                  state_q <= S_ISSUE;
                  valid_q <= 1'b1;
               end
            end
            S_ISSUE: begin
               if (instr_done) begin
                  pc_q      <= pc_d;
                  retired_q <= retired_q + INSTR_W'(1);
                  state_q   <= S_FETCH;
                  req_q     <= 1'b1;
                  valid_q   <= 1'b0;
               end
            end
            default: begin
               state_q <= S_FETCH;
               req_q   <= 1'b1;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign mem_rd_req  = req_q;
   assign mem_addr    = pc_q;
   assign pc          = pc_q;
   assign instr       = ir_q;
   assign OPcode      = ir_q[INSTR_W-1:OP_LSB];
   assign instr_valid = valid_q;
   assign retired     = retired_q;

endmodule
